// File: rtl/bus2_arbiter_pkg.sv
// Shared bus2 definitions: command encoding, bus widths, line geometry and
// the arbiter state encoding. Used by the cache controllers, MemCTR and
// bus2_arbiter.
package bus2_arbiter_pkg;

    localparam int ADDR2_BUS_SIZE  = 15;
    localparam int DATA_BUS_SIZE   = 16;
    localparam int CTR2_BUS_SIZE   = 2;
    localparam int CACHE_LINE_SIZE = 16;

    // Data beats per cache line and the width of a beat index
    localparam int BEATS  = CACHE_LINE_SIZE * 8 / DATA_BUS_SIZE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [CTR2_BUS_SIZE-1:0] {
        C2_NOP        = 2'd0,
        C2_READ_LINE  = 2'd1,
        C2_WRITE_LINE = 2'd2,
        C2_RESPONSE   = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WDATA    = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_RDATA    = 3'd4
    } arb_state_e;

    // A client is asking for the bus whenever it presents anything but NOP
    function automatic logic c2_is_request(input logic [CTR2_BUS_SIZE-1:0] cmd);
        return (cmd != C2_NOP);
    endfunction

endpackage

// File: rtl/bus2_arbiter_rr_picker_2.sv
// rr_picker_2: combinational two-way round-robin select. On contention the
// client that did not own the bus last wins; otherwise the single pending
// client wins.
module rr_picker_2 (
    input  logic [1:0] pending,
    input  logic       last_owner,
    output logic       winner,
    output logic       valid
);

    // Alternate on contention, otherwise take whichever client is pending
    always_comb begin
        valid = |pending;
        if (pending == 2'b11) begin
            winner = ~last_owner;
        end else if (pending[1]) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/bus2_arbiter.sv
// bus2_arbiter: two-client arbiter and transaction sequencer for bus2.
// Grants the bus round-robin, issues command/address/write beats to MemCTR,
// waits for C2_RESPONSE and routes read beats and completion back to the
// owning client.
// Optional feature: define BUS2_ARB_TIMEOUT_EN to enable a response
// watchdog that abandons a transaction after TIMEOUT wait cycles and
// pulses ERR for the owner. Without it ERR is tied to 0.
module bus2_arbiter
    import bus2_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [1:0][CTR2_BUS_SIZE-1:0]  REQ_C2,
    input  logic [1:0][ADDR2_BUS_SIZE-1:0] REQ_A2,
    input  logic [1:0][DATA_BUS_SIZE-1:0]  REQ_D2,
    output logic [1:0]                     GNT,
    output logic [1:0][CTR2_BUS_SIZE-1:0]  RSP_C2,
    output logic [1:0][DATA_BUS_SIZE-1:0]  RSP_D2,
    output logic [1:0]                     DONE,
    output logic [1:0]                     ERR,
    output logic [CTR2_BUS_SIZE-1:0]       M_C2,
    output logic [ADDR2_BUS_SIZE-1:0]      M_A2,
    output logic [DATA_BUS_SIZE-1:0]       M_D2,
    input  logic [CTR2_BUS_SIZE-1:0]       M_C2_IN,
    input  logic [DATA_BUS_SIZE-1:0]       M_D2_IN
);

    arb_state_e                state_r;
    logic                      owner_r;
    logic                      last_owner_r;
    logic [CTR2_BUS_SIZE-1:0]  cmd_r;
    logic [ADDR2_BUS_SIZE-1:0] addr_r;
    logic [BEAT_W-1:0]         beat_r;

    logic [1:0] pending_s;
    logic       pick_winner_s;
    logic       pick_valid_s;
    logic       rsp_hit_s;
    logic       is_write_s;
    logic       last_beat_s;
    logic       timeout_s;

    assign pending_s   = {c2_is_request(REQ_C2[1]), c2_is_request(REQ_C2[0])};
    assign rsp_hit_s   = (M_C2_IN == C2_RESPONSE);
    assign is_write_s  = (cmd_r == C2_WRITE_LINE);
    assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1));

    rr_picker_2 u_picker (
        .pending    (pending_s),
        .last_owner (last_owner_r),
        .winner     (pick_winner_s),
        .valid      (pick_valid_s)
    );

`ifdef BUS2_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] wait_cnt_r;

    // Count cycles spent waiting for MemCTR; cleared whenever not waiting
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ST_WAIT_RSP) && !rsp_hit_s && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // The TIMEOUT-th wait cycle without a response abandons the transaction
    assign timeout_s = (state_r == ST_WAIT_RSP) && !rsp_hit_s &&
                       (wait_cnt_r == TO_W'(TIMEOUT - 1));
`else
    // Watchdog compiled out: TIMEOUT stays on the interface but drives nothing
    logic timeout_unused_s;
    assign timeout_unused_s = (TIMEOUT > 0);
    assign timeout_s        = 1'b0;
`endif

    // Transaction sequencer: grant, issue, write beats, response, read beats
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            cmd_r        <= C2_NOP;
            addr_r       <= '0;
            beat_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        owner_r <= pick_winner_s;
                        cmd_r   <= REQ_C2[pick_winner_s];
                        addr_r  <= REQ_A2[pick_winner_s];
                        beat_r  <= '0;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Beat 0 goes out with the command, so the next beat is 1
                    beat_r <= BEAT_W'(1);
                    if (is_write_s && (BEATS > 1)) begin
                        state_r <= ST_WDATA;
                    end else begin
                        state_r <= ST_WAIT_RSP;
                    end
                end
                ST_WDATA: begin
                    if (last_beat_s) begin
                        beat_r  <= '0;
                        state_r <= ST_WAIT_RSP;
                    end else begin
                        beat_r  <= beat_r + BEAT_W'(1);
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_hit_s) begin
                        if (is_write_s || (BEATS == 1)) begin
                            last_owner_r <= owner_r;
                            state_r      <= ST_IDLE;
                        end else begin
                            beat_r  <= BEAT_W'(1);
                            state_r <= ST_RDATA;
                        end
                    end else if (timeout_s) begin
                        last_owner_r <= owner_r;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (last_beat_s) begin
                        beat_r       <= '0;
                        last_owner_r <= owner_r;
                        state_r      <= ST_IDLE;
                    end else begin
                        beat_r <= beat_r + BEAT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus and client outputs decoded from the current state and registers
    always_comb begin
        GNT    = 2'b00;
        RSP_C2 = '0;
        RSP_D2 = '0;
        DONE   = 2'b00;
        ERR    = 2'b00;
        M_C2   = C2_NOP;
        M_A2   = '0;
        M_D2   = '0;
        case (state_r)
            ST_ISSUE: begin
                GNT[owner_r] = 1'b1;
                M_C2         = cmd_r;
                M_A2         = addr_r;
                if (is_write_s) begin
                    M_D2 = REQ_D2[owner_r];
                end else begin
                    M_D2 = '0;
                end
            end
            ST_WDATA: begin
                GNT[owner_r] = 1'b1;
                M_D2         = REQ_D2[owner_r];
            end
            ST_WAIT_RSP: begin
                if (rsp_hit_s) begin
                    RSP_C2[owner_r] = C2_RESPONSE;
                    if (is_write_s) begin
                        DONE[owner_r] = 1'b1;
                    end else begin
                        RSP_D2[owner_r] = M_D2_IN;
                        DONE[owner_r]   = (BEATS == 1);
                    end
                end else if (timeout_s) begin
                    ERR[owner_r] = 1'b1;
                end else begin
                    ERR = 2'b00;
                end
            end
            ST_RDATA: begin
                RSP_D2[owner_r] = M_D2_IN;
                DONE[owner_r]   = last_beat_s;
            end
            default: begin
                GNT = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_bus2_arbiter.sv
// Self-checking bench for bus2_arbiter. A transaction-level model owns the
// client queues and the MemCTR responder; it walks each transaction's
// timeline and publishes the outputs the arbiter must show in every cycle,
// which a single negedge process compares. A monitor records issue order
// and latencies that are pinned against hand-computed constants.
module tb_bus2_arbiter;
    import bus2_arbiter_pkg::*;

    localparam int          TMO  = 20;
    localparam logic [15:0] JUNK = 16'hDEAD;

    logic                           CLK    = 1'b0;
    logic                           RESET  = 1'b0;
    logic [1:0][CTR2_BUS_SIZE-1:0]  REQ_C2 = '0;
    logic [1:0][ADDR2_BUS_SIZE-1:0] REQ_A2 = '0;
    logic [1:0][DATA_BUS_SIZE-1:0]  REQ_D2 = '0;
    logic [CTR2_BUS_SIZE-1:0]       M_C2_IN = 2'd0;
    logic [DATA_BUS_SIZE-1:0]       M_D2_IN = 16'd0;
    logic [1:0]                     GNT, DONE, ERR;
    logic [1:0][CTR2_BUS_SIZE-1:0]  RSP_C2;
    logic [1:0][DATA_BUS_SIZE-1:0]  RSP_D2;
    logic [CTR2_BUS_SIZE-1:0]       M_C2;
    logic [ADDR2_BUS_SIZE-1:0]      M_A2;
    logic [DATA_BUS_SIZE-1:0]       M_D2;

    always #5 CLK = ~CLK;

    bus2_arbiter #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_C2(REQ_C2), .REQ_A2(REQ_A2), .REQ_D2(REQ_D2),
        .GNT(GNT), .RSP_C2(RSP_C2), .RSP_D2(RSP_D2), .DONE(DONE), .ERR(ERR),
        .M_C2(M_C2), .M_A2(M_A2), .M_D2(M_D2),
        .M_C2_IN(M_C2_IN), .M_D2_IN(M_D2_IN)
    );

    // lat = wait cycle carrying the response (0: never respond)
    // abort_k = read beat during which reset is asserted (0: none)
    typedef struct {
        logic [1:0]  cmd;
        logic [14:0] addr;
        logic [15:0] base;
        int          lat;
        int          abort_k;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   m_last = 1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [1:0]                     exp_gnt, exp_done, exp_err;
    logic [1:0][CTR2_BUS_SIZE-1:0]  exp_rsp_c2;
    logic [1:0][DATA_BUS_SIZE-1:0]  exp_rsp_d2;
    logic [CTR2_BUS_SIZE-1:0]       exp_m_c2;
    logic [ADDR2_BUS_SIZE-1:0]      exp_m_a2;
    logic [DATA_BUS_SIZE-1:0]       exp_m_d2;

    int          cyc = 0;
    int          iss_owner[$];
    int          iss_cyc[$];
    int          done_cyc[$];
    logic [15:0] rsp_beats[$];
    int          gnt_hi[2];
    logic [1:0]  prev_gnt = 2'b00;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, got, want);
        end
    endtask

    function automatic logic [15:0] rbeat(input logic [15:0] base, input int k);
        return base + 16'(k) * 16'h0101;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Per-cycle comparison of every DUT output against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("GNT",    64'(GNT),    64'(exp_gnt));
            chk("RSP_C2", 64'(RSP_C2), 64'(exp_rsp_c2));
            chk("RSP_D2", 64'(RSP_D2), 64'(exp_rsp_d2));
            chk("DONE",   64'(DONE),   64'(exp_done));
            chk("ERR",    64'(ERR),    64'(exp_err));
            chk("M_C2",   64'(M_C2),   64'(exp_m_c2));
            chk("M_A2",   64'(M_A2),   64'(exp_m_a2));
            chk("M_D2",   64'(M_D2),   64'(exp_m_d2));
        end
    end

    // Event log used by the literal pins
    always @(negedge CLK) begin
        cyc++;
        if (RESET && (GNT != 2'b00) && (prev_gnt == 2'b00)) begin
            iss_owner.push_back(GNT[1] ? 1 : 0);
            iss_cyc.push_back(cyc);
        end
        if (GNT[0] === 1'b1) gnt_hi[0]++;
        if (GNT[1] === 1'b1) gnt_hi[1]++;
        if (DONE != 2'b00) done_cyc.push_back(cyc);
        if ((RSP_C2[0] == C2_RESPONSE) || (RSP_C2[1] == C2_RESPONSE))
            rsp_beats.push_back(RSP_D2[0] | RSP_D2[1]);
        prev_gnt = GNT;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_exp();
        exp_gnt    = 2'b00;
        exp_rsp_c2 = '0;
        exp_rsp_d2 = '0;
        exp_done   = 2'b00;
        exp_err    = 2'b00;
        exp_m_c2   = C2_NOP;
        exp_m_a2   = '0;
        exp_m_d2   = '0;
    endtask

    task automatic clr_log();
        iss_owner.delete(); iss_cyc.delete(); done_cyc.delete(); rsp_beats.delete();
        gnt_hi[0] = 0; gnt_hi[1] = 0;
    endtask

    task automatic present();
        REQ_C2 = '0;
        if (q0.size() > 0) begin
            REQ_C2[0] = q0[0].cmd; REQ_A2[0] = q0[0].addr; REQ_D2[0] = q0[0].base;
        end
        if (q1.size() > 0) begin
            REQ_C2[1] = q1[0].cmd; REQ_A2[1] = q1[0].addr; REQ_D2[1] = q1[0].base;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0; REQ_C2 = '0; M_C2_IN = C2_NOP; M_D2_IN = JUNK;
        clr_exp();
        step();
        chk_en = 1'b1;
        step();
        chk("rst_gnt", 64'(GNT), 64'd0);
        chk("rst_m_c2", 64'(M_C2), 64'd0);
        RESET  = 1'b1;
        m_last = 1;
    endtask

    // Walk every queued transaction cycle by cycle, publishing expectations
    task automatic run_all();
        txn_t t;
        int   w;
        bit   wr;
        bit   aborted;
        logic [15:0] d;
        while ((q0.size() > 0) || (q1.size() > 0)) begin
            present(); M_C2_IN = C2_NOP; M_D2_IN = JUNK; clr_exp();
            step();
            if ((q0.size() > 0) && (q1.size() > 0)) w = (m_last == 0) ? 1 : 0;
            else w = (q0.size() > 0) ? 0 : 1;
            t  = (w == 0) ? q0.pop_front() : q1.pop_front();
            wr = (t.cmd == C2_WRITE_LINE);
            clr_exp();
            exp_gnt[w] = 1'b1; exp_m_c2 = t.cmd; exp_m_a2 = t.addr;
            exp_m_d2   = wr ? t.base : 16'h0000;
            step();
            if (wr) begin
                for (int k = 1; k < BEATS; k++) begin
                    d = t.base + 16'(k);
                    REQ_D2[w] = d;
                    clr_exp(); exp_gnt[w] = 1'b1; exp_m_d2 = d;
                    step();
                end
            end
            if (t.lat == 0) begin
                for (int i = 1; i <= TMO; i++) begin
                    M_C2_IN = C2_NOP; M_D2_IN = JUNK;
                    clr_exp(); exp_err[w] = (i == TMO);
                    step();
                end
            end else begin
                for (int i = 1; i <= t.lat; i++) begin
                    clr_exp();
                    if (i == t.lat) begin
                        M_C2_IN = C2_RESPONSE; M_D2_IN = rbeat(t.base, 0);
                        exp_rsp_c2[w] = C2_RESPONSE;
                        if (wr) exp_done[w] = 1'b1;
                        else exp_rsp_d2[w] = rbeat(t.base, 0);
                    end else begin
                        M_C2_IN = C2_NOP; M_D2_IN = JUNK;
                    end
                    step();
                end
            end
            aborted = 1'b0;
            if (!wr && (t.lat != 0)) begin
                for (int k = 1; k < BEATS; k++) begin
                    M_C2_IN = C2_NOP; M_D2_IN = rbeat(t.base, k);
                    clr_exp();
                    exp_rsp_d2[w] = rbeat(t.base, k);
                    exp_done[w]   = (k == BEATS - 1);
                    if (k == t.abort_k) RESET = 1'b0;
                    step();
                    if (!RESET) begin
                        RESET   = 1'b1;
                        aborted = 1'b1;
                        break;
                    end
                end
            end
            m_last = aborted ? 1 : w;
        end
        present(); M_C2_IN = C2_NOP; M_D2_IN = JUNK; clr_exp();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clr_exp();
        do_reset();

        // Single read by client 0, response in wait cycle 10
        clr_log();
        q0.push_back('{C2_READ_LINE, 15'h0012, 16'h0100, 10, 0});
        run_all();
        chk("s1_issues", 64'(iss_owner.size()), 64'd1);
        chk("s1_owner", 64'(qget(iss_owner, 0)), 64'd0);
        chk("s1_latency", 64'(qget(done_cyc, 0) - qget(iss_cyc, 0)), 64'd17);
        chk("s1_beat0", 64'(rsp_beats.size() > 0 ? rsp_beats[0] : 16'h0000), 64'h0100);
        chk("s1_gnt_cycles", 64'(gnt_hi[0]), 64'd1);

        // Single write by client 1, beats 0xA0A0+k, response in wait cycle 3
        clr_log();
        q1.push_back('{C2_WRITE_LINE, 15'h0345, 16'hA0A0, 3, 0});
        run_all();
        chk("s2_owner", 64'(qget(iss_owner, 0)), 64'd1);
        chk("s2_gnt_cycles", 64'(gnt_hi[1]), 64'd8);
        chk("s2_latency", 64'(qget(done_cyc, 0) - qget(iss_cyc, 0)), 64'd10);

        // Contention after reset: service order alternates 0,1,0,1
        do_reset();
        clr_log();
        q0.push_back('{C2_READ_LINE, 15'h0100, 16'h1100, 2, 0});
        q0.push_back('{C2_READ_LINE, 15'h0101, 16'h2200, 1, 0});
        q1.push_back('{C2_WRITE_LINE, 15'h0200, 16'hB0B0, 2, 0});
        q1.push_back('{C2_WRITE_LINE, 15'h0201, 16'hC0C0, 4, 0});
        run_all();
        chk("s3_n_issue", 64'(iss_owner.size()), 64'd4);
        chk("s3_order0", 64'(qget(iss_owner, 0)), 64'd0);
        chk("s3_order1", 64'(qget(iss_owner, 1)), 64'd1);
        chk("s3_order2", 64'(qget(iss_owner, 2)), 64'd0);
        chk("s3_order3", 64'(qget(iss_owner, 3)), 64'd1);
        chk("s3_gap", 64'(qget(iss_cyc, 1) - qget(done_cyc, 0)), 64'd2);

        // Reset during read beat 3, then a fresh read completes normally
        do_reset();
        clr_log();
        q0.push_back('{C2_READ_LINE, 15'h0033, 16'h3300, 2, 3});
        q0.push_back('{C2_READ_LINE, 15'h0034, 16'h4400, 2, 0});
        run_all();
        chk("s4_n_issue", 64'(iss_owner.size()), 64'd2);
        chk("s4_n_done", 64'(done_cyc.size()), 64'd1);

        // Starvation: client 1's held write goes right after one client-0 read
        do_reset();
        clr_log();
        q0.push_back('{C2_READ_LINE, 15'h0050, 16'h5000, 1, 0});
        q0.push_back('{C2_READ_LINE, 15'h0051, 16'h5100, 1, 0});
        q0.push_back('{C2_READ_LINE, 15'h0052, 16'h5200, 1, 0});
        q1.push_back('{C2_WRITE_LINE, 15'h0060, 16'hD0D0, 1, 0});
        run_all();
        chk("s5_order0", 64'(qget(iss_owner, 0)), 64'd0);
        chk("s5_order1", 64'(qget(iss_owner, 1)), 64'd1);
        chk("s5_order2", 64'(qget(iss_owner, 2)), 64'd0);
        chk("s5_order3", 64'(qget(iss_owner, 3)), 64'd0);

`ifdef BUS2_ARB_TIMEOUT_EN
        // Watchdog: no response, ERR on wait cycle TMO, late response ignored
        do_reset();
        clr_log();
        q1.push_back('{C2_READ_LINE, 15'h0077, 16'h7700, 0, 0});
        run_all();
        REQ_C2 = '0; M_C2_IN = C2_RESPONSE; M_D2_IN = 16'h1234; clr_exp();
        step();
        M_C2_IN = C2_NOP; M_D2_IN = JUNK;
        step();
        q0.push_back('{C2_READ_LINE, 15'h0078, 16'h7800, 1, 0});
        run_all();
        chk("s6_n_done", 64'(done_cyc.size()), 64'd1);
        chk("s6_owner1", 64'(qget(iss_owner, 1)), 64'd0);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
